// File: rtl/seg7_frame_display.sv
// Receives (digit, position) beats, commits complete frames to a display buffer and
// scans them onto a 4-digit common-anode display. Optional: LEADING_ZERO_BLANK_EN.
module seg7_frame_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic [3:0] digit_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done,
  output logic       seq_err
);

  typedef enum logic [1:0] {WAIT_D3, WAIT_D2, WAIT_D1, WAIT_D0} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0][3:0]  r_shadow;
  logic [3:0][3:0]  r_disp;
  logic             w_ld3, w_ld2, w_ld1, w_commit, w_err;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             w_wrap;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_D3;
    else     r_state <= w_state_nxt;
  end

  // A D3 beat always (re)starts a frame, whatever state the capture is in.
  always_comb begin
    w_state_nxt = r_state;
    w_ld3       = 1'b0;
    w_ld2       = 1'b0;
    w_ld1       = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    if (digit_sel == 4'h8) begin
      w_ld3       = 1'b1;
      w_state_nxt = WAIT_D2;
    end else begin
      case (r_state)
        WAIT_D3: w_state_nxt = WAIT_D3;
        WAIT_D2: begin
          if (digit_sel == 4'h4) begin
            w_ld2       = 1'b1;
            w_state_nxt = WAIT_D1;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = WAIT_D3;
          end
        end
        WAIT_D1: begin
          if (digit_sel == 4'h2) begin
            w_ld1       = 1'b1;
            w_state_nxt = WAIT_D0;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = WAIT_D3;
          end
        end
        default: begin
          if (digit_sel == 4'h1) w_commit = 1'b1;
          else                   w_err    = 1'b1;
          w_state_nxt = WAIT_D3;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow   <= '0;
      r_disp     <= '0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      if (w_ld3) r_shadow[3] <= digit_in;
      if (w_ld2) r_shadow[2] <= digit_in;
      if (w_ld1) r_shadow[1] <= digit_in;
      if (w_commit) r_disp <= {r_shadow[3], r_shadow[2], r_shadow[1], digit_in};
      frame_done <= w_commit;
      seq_err    <= w_err;
    end
  end

  assign w_wrap  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_digit = r_disp[r_idx];

  always_comb begin
    w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (r_idx)
      2'd3:    w_blank = (r_disp[3] == 4'h0);
      2'd2:    w_blank = (r_disp[3] == 4'h0) && (r_disp[2] == 4'h0);
      2'd1:    w_blank = (r_disp[3] == 4'h0) && (r_disp[2] == 4'h0) && (r_disp[1] == 4'h0);
      default: w_blank = 1'b0;
    endcase
`endif
  end

  always_comb begin
    w_seg = 7'h7F;
    case (w_digit)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      default: w_seg = 7'h0E;
    endcase
    if (w_blank) w_seg = 7'h7F;
  end

  // Scan index walks 3,2,1,0 by plain 2-bit decrement; outputs lag it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd3;
      an    <= 4'hF;
      seg   <= 7'h7F;
    end else begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx - 2'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      an  <= ~(4'b0001 << r_idx);
      seg <= w_seg;
    end
  end

endmodule
